// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use stalls,
// branch/jump redirects, memory-wait freezes, timeout halt and perf counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_Branch,
  input  logic             ex_taken,
  input  logic             ex_Jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;

  logic active;
  logic freeze;
  logic redirect_raw;
  logic load_use_raw;
  logic do_freeze;
  logic do_redirect;
  logic do_load_use;

  // Handshake: mem_req/mem_ready is a plain request/complete pair; the access
  // retires on the cycle mem_ready is high, any cycle with mem_req high and
  // mem_ready low holds the whole pipe up to EX/MEM.
  always_comb begin
    active       = (state == S_RUN) || (state == S_MEM_WAIT);
    freeze       = mem_req & ~mem_ready;
    redirect_raw = (ex_Branch & ex_taken) | ex_Jump;
    load_use_raw = ex_MemRead && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    do_freeze    = active & freeze;
    do_redirect  = active & ~freeze & redirect_raw;
    do_load_use  = active & ~freeze & ~redirect_raw & load_use_raw;
  end

  always_comb begin
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    if (!active) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (do_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (do_redirect) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (do_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // wait_cnt counts not-ready cycles including the one that entered MEM_WAIT.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_INIT: state_nxt = S_RUN;
      S_RUN: begin
        if (freeze) begin
          state_nxt = S_MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      S_MEM_WAIT: begin
        if (!freeze) begin
          state_nxt = S_RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          state_nxt = S_HALT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((do_freeze || do_load_use) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (do_redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign halted    = (state == S_HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a default instance plus a short-timeout
// and a narrow-counter instance, all sharing one stimulus stream.
module tb_hazard_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_MemRead;
  logic       ex_Branch, ex_taken, ex_Jump, mem_req, mem_ready;

  int n_checks = 0;
  int n_err    = 0;

  // Output vector: {pc_write,pc_redirect,ifid_write,ifid_flush,idex_write,
  //                 idex_flush,exmem_write,memwb_flush,halted}
  localparam logic [8:0] O_INIT   = 9'b000101010;
  localparam logic [8:0] O_HALT   = 9'b000101011;
  localparam logic [8:0] O_NORMAL = 9'b101010100;
  localparam logic [8:0] O_LU     = 9'b000011100;
  localparam logic [8:0] O_REDIR  = 9'b111111100;
  localparam logic [8:0] O_FREEZE = 9'b000000010;

  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [8:0]  o_main, o_to, o_sat;
  logic [15:0] stall_main, flush_main, stall_to, flush_to;
  logic [3:0]  stall_sat, flush_sat;
  logic [1:0]  st_main, st_to, st_sat;

  logic pw0, pr0, iw0, if0, xw0, xf0, ew0, mf0, h0;
  logic pw1, pr1, iw1, if1, xw1, xf1, ew1, mf1, h1;
  logic pw2, pr2, iw2, if2, xw2, xf2, ew2, mf2, h2;

  assign o_main = {pw0, pr0, iw0, if0, xw0, xf0, ew0, mf0, h0};
  assign o_to   = {pw1, pr1, iw1, if1, xw1, xf1, ew1, mf1, h1};
  assign o_sat  = {pw2, pr2, iw2, if2, xw2, xf2, ew2, mf2, h2};

  hazard_sequencer dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead),
    .ex_rd(ex_rd), .ex_Branch(ex_Branch), .ex_taken(ex_taken), .ex_Jump(ex_Jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pw0), .pc_redirect(pr0), .ifid_write(iw0), .ifid_flush(if0),
    .idex_write(xw0), .idex_flush(xf0), .exmem_write(ew0), .memwb_flush(mf0),
    .halted(h0), .stall_cnt(stall_main), .flush_cnt(flush_main), .fsm_state(st_main)
  );

  hazard_sequencer #(.MEM_TIMEOUT(3)) dut_to (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead),
    .ex_rd(ex_rd), .ex_Branch(ex_Branch), .ex_taken(ex_taken), .ex_Jump(ex_Jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pw1), .pc_redirect(pr1), .ifid_write(iw1), .ifid_flush(if1),
    .idex_write(xw1), .idex_flush(xf1), .exmem_write(ew1), .memwb_flush(mf1),
    .halted(h1), .stall_cnt(stall_to), .flush_cnt(flush_to), .fsm_state(st_to)
  );

  hazard_sequencer #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead),
    .ex_rd(ex_rd), .ex_Branch(ex_Branch), .ex_taken(ex_taken), .ex_Jump(ex_Jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pw2), .pc_redirect(pr2), .ifid_write(iw2), .ifid_flush(if2),
    .idex_write(xw2), .idex_flush(xf2), .exmem_write(ew2), .memwb_flush(mf2),
    .halted(h2), .stall_cnt(stall_sat), .flush_cnt(flush_sat), .fsm_state(st_sat)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_rd = 5'd0; ex_Branch = 1'b0; ex_taken = 1'b0;
    ex_Jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_MemRead = 1'b1; ex_rd = rd; id_rs2 = rd; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("rst_outputs", 32'(o_main), 32'(O_INIT));
      chk("rst_stall", 32'(stall_main), 32'd0);
      chk("rst_flush", 32'(flush_main), 32'd0);
    end
    rst = 1'b1; #1;
    chk("init_cycle", 32'(o_main), 32'(O_INIT));
    next_cycle(); #1;
    chk("run_normal", 32'(o_main), 32'(O_NORMAL));
    chk("run_state", 32'(st_main), 32'(ST_RUN));
    chk("run_cnts", 32'({stall_main, flush_main}), 32'd0);

    // Load-use on rs2
    next_cycle(); set_load_use(5'd5); #1;
    chk("lu_rs2", 32'(o_main), 32'(O_LU));
    next_cycle(); idle_inputs(); #1;
    chk("lu_after", 32'(o_main), 32'(O_NORMAL));
    chk("lu_stall1", 32'(stall_main), 32'd1);

    // ex_rd = x0 never stalls
    set_load_use(5'd0); #1;
    chk("lu_x0", 32'(o_main), 32'(O_NORMAL));
    next_cycle(); idle_inputs();
    // Load-use on rs1, and the same match with use_rs1 clear
    ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; #1;
    chk("lu_x0_stall", 32'(stall_main), 32'd1);
    chk("lu_rs1", 32'(o_main), 32'(O_LU));
    next_cycle(); id_use_rs1 = 1'b0; #1;
    chk("lu_rs1_stall", 32'(stall_main), 32'd2);
    chk("lu_unused", 32'(o_main), 32'(O_NORMAL));

    // Jump beats load-use
    next_cycle(); idle_inputs(); set_load_use(5'd9); ex_Jump = 1'b1; #1;
    chk("jump_lu", 32'(o_main), 32'(O_REDIR));
    next_cycle(); idle_inputs(); #1;
    chk("jump_flush", 32'(flush_main), 32'd1);
    chk("jump_stall", 32'(stall_main), 32'd2);

    // Taken and not-taken branches
    ex_Branch = 1'b1; ex_taken = 1'b1; #1;
    chk("br_taken", 32'(o_main), 32'(O_REDIR));
    next_cycle(); ex_taken = 1'b0; #1;
    chk("br_nt", 32'(o_main), 32'(O_NORMAL));
    chk("br_flush", 32'(flush_main), 32'd2);

    // Memory wait: four not-ready cycles then ready
    next_cycle(); idle_inputs(); mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("freeze_out", 32'(o_main), 32'(O_FREEZE));
      next_cycle();
    end
    mem_ready = 1'b1; #1;
    chk("wait_state", 32'(st_main), 32'(ST_WAIT));
    chk("wait_stall", 32'(stall_main), 32'd6);
    chk("release_out", 32'(o_main), 32'(O_NORMAL));
    next_cycle(); idle_inputs(); #1;
    chk("release_state", 32'(st_main), 32'(ST_RUN));
    chk("release_stall", 32'(stall_main), 32'd6);

    // Jump during freeze is ignored, then taken on the release cycle
    mem_req = 1'b1; ex_Jump = 1'b1; #1;
    chk("freeze_jump", 32'(o_main), 32'(O_FREEZE));
    next_cycle(); mem_ready = 1'b1; #1;
    chk("freeze_jump_flush", 32'(flush_main), 32'd2);
    chk("release_jump", 32'(o_main), 32'(O_REDIR));
    next_cycle(); idle_inputs(); #1;
    chk("release_jump_flush", 32'(flush_main), 32'd3);
    chk("release_jump_stall", 32'(stall_main), 32'd7);

    // Timeout with MEM_TIMEOUT=3
    reset_all(); mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_freeze", 32'(o_to), 32'(O_FREEZE));
      next_cycle();
    end
    #1;
    chk("to_halt", 32'(o_to), 32'(O_HALT));
    chk("main_not_halted", 32'(h0), 32'd0);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("to_halt_sticky", 32'(o_to), 32'(O_HALT));
    rst = 1'b0; #1;
    chk("to_async_clear", 32'(o_to), 32'(O_INIT));
    chk("to_async_stall", 32'(stall_to), 32'd0);
    next_cycle(); idle_inputs(); rst = 1'b1;
    next_cycle(); #1;
    chk("to_rerun", 32'(o_to), 32'(O_NORMAL));

    // Saturation with CNT_W=4
    next_cycle(); set_load_use(5'd3);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_lu", 32'(o_sat), 32'(O_LU));
      chk("sat_cnt", 32'(stall_sat), (i < 15) ? 32'(i) : 32'd15);
      next_cycle();
    end
    idle_inputs(); #1;
    chk("sat_final", 32'(stall_sat), 32'd15);
    chk("sat_flush", 32'(flush_sat), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
